// File: rtl/uart_frame_assembler.sv
// Packs four little-endian UART bytes into a 32-bit remote-state frame and publishes it atomically.
// Also discards frames on gap timeout or bad marker, and tracks link health in timing_tick units.
module uart_frame_assembler #(
  parameter int unsigned GAP_CYCLES = 200000,
  parameter int unsigned LINK_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done_tick,
  input  logic        timing_tick,
  output logic [31:0] rx_buf,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        link_ok
);

  localparam int unsigned GapW  = $clog2(GAP_CYCLES) + 1;
  localparam int unsigned TickW = $clog2(LINK_TICKS + 1);
  localparam logic [GapW-1:0]  GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(LINK_TICKS);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCommit
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       shadow_q, shadow_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic              seen_q, seen_d;
  logic [31:0]       rx_buf_q, rx_buf_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              link_ok_q, link_ok_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shadow_q      <= 24'h0;
      cnt_q         <= 2'd0;
      gap_q         <= '0;
      tick_q        <= TickMax;
      seen_q        <= 1'b0;
      rx_buf_q      <= 32'h0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      link_ok_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      tick_q        <= tick_d;
      seen_q        <= seen_d;
      rx_buf_q      <= rx_buf_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      link_ok_q     <= link_ok_d;
    end
  end

  // Frame FSM. rx_buf is loaded on entry to StCommit, so it and frame_valid change together.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    rx_buf_d      = rx_buf_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      StIdle, StCommit: begin
        state_d = StIdle;
        if (rx_done_tick) begin
          shadow_d[7:0] = rx_data;
          cnt_d         = 2'd1;
          gap_d         = '0;
          state_d       = StRecv;
        end
      end
      StRecv: begin
        if (rx_done_tick) begin
          gap_d = '0;
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            if (rx_data[7]) begin
              rx_buf_d      = {rx_data, shadow_q};
              frame_valid_d = 1'b1;
              state_d       = StCommit;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StIdle;
            end
          end else begin
            if (cnt_q == 2'd1) begin
              shadow_d[15:8] = rx_data;
            end else begin
              shadow_d[23:16] = rx_data;
            end
            cnt_d = cnt_q + 2'd1;
          end
        end else if (gap_q == GapLast) begin
          frame_err_d = 1'b1;
          cnt_d       = 2'd0;
          gap_d       = '0;
          state_d     = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
        gap_d   = '0;
      end
    endcase
  end

  // Link monitor: link_ok is computed from next-state values so it rises the cycle after
  // frame_valid.
  always_comb begin
    tick_d = tick_q;
    seen_d = seen_q;
    if (frame_valid_q) begin
      tick_d = '0;
      seen_d = 1'b1;
    end else if (timing_tick && (tick_q < TickMax)) begin
      tick_d = tick_q + TickW'(1);
    end
    link_ok_d = seen_d && (tick_d < TickMax);
  end

  assign rx_buf      = rx_buf_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign link_ok     = link_ok_q;

endmodule

// File: doc/uart_frame_assembler.md
Name: uart_frame_assembler

Overview:
- Sits between the UART receiver byte output and the game logic's 32-bit remote-state word. The game logic slices that word into y_player2 [30:21], y_ball [20:11] and x_ball [10:0].
- Collects four received bytes into one 32-bit frame and checks the marker bit. It then publishes the frame atomically, so a half-updated word never reaches the player-2 / ball multiplexer.
- Realigns on inter-byte gaps, flags malformed frames, and reports link health in timing_tick units. Game logic uses link health to fall back to local control.

Parameters:
- GAP_CYCLES, 200000: max clk cycles allowed between bytes inside one frame before the partial frame is discarded.
- LINK_TICKS, 8: number of timing_tick pulses without a valid frame before link_ok drops.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_data  input  8  byte from UART receiver; valid only when rx_done_tick=1
- rx_done_tick  input  1  one-cycle strobe, new byte available
- timing_tick  input  1  one-cycle game frame tick
- rx_buf  output  32  last valid frame; bit 31 is marker (always 1 once loaded)
- frame_valid  output  1  one-cycle pulse, asserted in the same cycle rx_buf takes a new value
- frame_err  output  1  one-cycle pulse on a discarded frame (gap timeout or bad marker)
- link_ok  output  1  high while valid frames are arriving

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All state is updated only on rising clk.
  - rst is synchronous, active-high, and overrides every other input.
- Reset values:
  - rx_buf=32'h0, frame_valid=0, frame_err=0, link_ok=0.
  - FSM=IDLE; byte counter=0; gap counter=0; tick counter=LINK_TICKS; seen_valid=0.
- Byte order is little-endian:
  - byte0 → [7:0], byte1 → [15:8], byte2 → [23:16], byte3 → [31:24].
  - The marker is byte3[7].
- FSM states:
  - IDLE:
    - On rx_done_tick: shadow[7:0] <= rx_data, byte count <= 1, gap counter <= 0, go to RECV.
  - RECV:
    - On rx_done_tick with count 1 or 2: store the byte in its lane, count++, gap counter <= 0.
    - On rx_done_tick with count 3 and rx_data[7]=1, go to COMMIT.
    - On rx_done_tick with count 3 and rx_data[7]=0: frame_err pulse next cycle, go to IDLE. rx_buf is unchanged.
    - With no rx_done_tick, the gap counter increments.
    - When the gap counter reaches GAP_CYCLES-1: frame_err pulse, go to IDLE, partial frame dropped.
  - COMMIT (one cycle):
    - rx_buf <= {byte3, shadow[23:0]} and frame_valid=1 in that cycle.
    - Go to IDLE.
    - A byte arriving during COMMIT is taken as byte0 of the next frame: go to RECV with count 1.
- Latency: rx_buf and frame_valid update 1 clk after the 4th rx_done_tick (registered outputs).
- Simultaneous events:
  - rx_done_tick in the same cycle as gap expiry: the byte wins, counter reset, no error.
- Shadow register:
  - The shadow never drives rx_buf directly.
  - rx_buf changes only in COMMIT, so all 32 bits change together.
- Link monitor:
  - Tick counter: 0 on frame_valid. Otherwise it increments on timing_tick and saturates at LINK_TICKS.
  - frame_valid and timing_tick in the same cycle: counter cleared to 0 (valid wins).
  - seen_valid is set on the first frame_valid and cleared only by rst.
  - link_ok is registered: seen_valid && (tick counter < LINK_TICKS).
  - After the first valid frame, link_ok rises 1 clk after frame_valid.
- Gap counter width is $clog2(GAP_CYCLES)+1. The tick counter must hold LINK_TICKS.
- rst mid-frame: partial frame discarded, no frame_err, rx_buf returns to 0.

Test Plan:
- Reset, then bytes 0x55,0x3A,0x91,0xC4 with 10 cycles spacing → frame_valid pulse 1 clk after 4th strobe; rx_buf=32'hC4913A55; link_ok=1 one clk later; frame_err never asserted.
- Bytes 0x01,0x02,0x03,0x7F (marker 0) → frame_err one pulse, rx_buf keeps previous value, no frame_valid.
- Two bytes, then silence ≥GAP_CYCLES, then four good bytes 0x00,0x00,0x00,0x80 → one frame_err at gap expiry; then rx_buf=32'h80000000 with frame_valid (realigned).
- Good frame, then 8 timing_ticks with no bytes → link_ok falls after 8th tick; next good frame → link_ok returns to 1, counter 0.
- rst asserted after 3rd byte → outputs at reset values; subsequent good frame assembled correctly from byte0; no spurious frame_err.
- Byte strobe exactly on gap-expiry cycle, plus frame_valid coincident with timing_tick → no frame_err; frame completes; link counter 0 and link_ok stays high.
